lane_tracker_stream: RTL and testbench

Parametrised successor to the single-row lane-centre controller. Accepts a pixel row of `ROW_W` samples over a valid/ready stream and computes an internal 1-D edge gradient. It finds the strongest left-half and right-half edges above a threshold and emits the lane centre and confidence through a valid/ready result port. When a lane is missing it holds the last good centre for up to `HOLD_ROWS` rows before flagging loss, and it can run row-after-row without a `start` pulse.

---
 rtl/lane_tracker_stream.sv | 256 +++++++++++++++++++++++++
 tb/tb_lane_tracker_stream.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_tracker_stream.sv
// rtl/lane_tracker_stream.sv - Row edge-gradient lane centre tracker with hold-on-miss and stream I/O
module lane_tracker_stream #(
    parameter int ROW_W        = 32,
    parameter int PIX_W        = 8,
    parameter int THRESH       = 20,
    parameter int HOLD_ROWS    = 2,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PIX_W-1:0]         rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [$clog2(ROW_W)-1:0] tx_center,
    output logic [7:0]               tx_confidence,
    output logic                     tx_lost,
    output logic                     tx_valid,
    input  logic                     tx_ready
);

    localparam int IDX_W  = $clog2(ROW_W);
    localparam int HALF   = (ROW_W - 2) / 2;
    localparam int LAST_K = ROW_W - 3;
    localparam int MISS_W = (HOLD_ROWS < 1) ? 1 : $clog2(HOLD_ROWS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECEIVE,
        S_SCAN,
        S_CALC,
        S_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   pix_q [ROW_W];
    logic [PIX_W-1:0]   pix_d [ROW_W];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic               issue_done_q, issue_done_d;

    // Gradient magnitude is registered before the peak compare so the
    // subtract/abs path and the compare/select path sit in separate cycles.
    logic               grad_v_q, grad_v_d;
    logic [PIX_W-1:0]   grad_a_q, grad_a_d;
    logic [IDX_W-1:0]   grad_k_q, grad_k_d;

    logic [PIX_W-1:0]   pk_l_val_q, pk_l_val_d;
    logic [PIX_W-1:0]   pk_r_val_q, pk_r_val_d;
    logic [IDX_W-1:0]   pk_l_pos_q, pk_l_pos_d;
    logic [IDX_W-1:0]   pk_r_pos_q, pk_r_pos_d;

    logic [IDX_W-1:0]   last_center_q, last_center_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]   tx_center_q, tx_center_d;
    logic [7:0]         tx_conf_q, tx_conf_d;
    logic               tx_lost_q, tx_lost_d;
    logic               tx_valid_q, tx_valid_d;

    logic [IDX_W-1:0]   k_far;
    logic signed [PIX_W:0] grad;
    logic [PIX_W-1:0]   grad_abs;

    logic               pk_found;
    logic [PIX_W+1:0]   pk_sum;
    logic [PIX_W+1:0]   pk_avg;
    logic [7:0]         conf_sat;
    logic [IDX_W:0]     pos_sum;
    logic [IDX_W-1:0]   centre;

    assign rx_ready      = (state_q == S_RECEIVE);
    assign tx_center     = tx_center_q;
    assign tx_confidence = tx_conf_q;
    assign tx_lost       = tx_lost_q;
    assign tx_valid      = tx_valid_q;

    // Central-difference gradient g[k] = pix[k+2] - pix[k] and its magnitude.
    always_comb begin
        k_far    = k_q + IDX_W'(2);
        grad     = $signed({1'b0, pix_q[k_far]}) - $signed({1'b0, pix_q[k_q]});
        grad_abs = grad[PIX_W] ? PIX_W'(-grad) : grad[PIX_W-1:0];
    end

    // Lane centre and saturated mean peak strength from the two half-row peaks.
    always_comb begin
        pk_found = (pk_l_val_q != '0) && (pk_r_val_q != '0);
        pk_sum   = {2'b00, pk_l_val_q} + {2'b00, pk_r_val_q};
        pk_avg   = pk_sum >> 1;
        conf_sat = (32'(pk_avg) > 32'd255) ? 8'hFF : 8'(pk_avg);
        pos_sum  = {1'b0, pk_l_pos_q} + {1'b0, pk_r_pos_q};
        centre   = IDX_W'(pos_sum >> 1);
    end

    // Next-state and datapath updates for receive, scan, calc and send.
    always_comb begin
        state_d       = state_q;
        pix_d         = pix_q;
        idx_d         = idx_q;
        k_d           = k_q;
        issue_done_d  = issue_done_q;
        grad_v_d      = grad_v_q;
        grad_a_d      = grad_a_q;
        grad_k_d      = grad_k_q;
        pk_l_val_d    = pk_l_val_q;
        pk_r_val_d    = pk_r_val_q;
        pk_l_pos_d    = pk_l_pos_q;
        pk_r_pos_d    = pk_r_pos_q;
        last_center_d = last_center_q;
        miss_cnt_d    = miss_cnt_q;
        tx_center_d   = tx_center_q;
        tx_conf_d     = tx_conf_q;
        tx_lost_d     = tx_lost_q;
        tx_valid_d    = tx_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RECEIVE;
                    idx_d   = '0;
                end
            end

            S_RECEIVE: begin
                if (rx_valid && rx_ready) begin
                    pix_d[idx_q] = rx_data;
                    if (idx_q == IDX_W'(ROW_W - 1)) begin
                        state_d      = S_SCAN;
                        k_d          = '0;
                        issue_done_d = 1'b0;
                        grad_v_d     = 1'b0;
                        pk_l_val_d   = '0;
                        pk_r_val_d   = '0;
                        pk_l_pos_d   = '0;
                        pk_r_pos_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_SCAN: begin
                // Strict compares keep the lowest index on equal magnitudes.
                if (grad_v_q) begin
                    if (grad_k_q < IDX_W'(HALF)) begin
                        if ((32'(grad_a_q) > THRESH) && (grad_a_q > pk_l_val_q)) begin
                            pk_l_val_d = grad_a_q;
                            pk_l_pos_d = grad_k_q;
                        end
                    end else begin
                        if ((32'(grad_a_q) > THRESH) && (grad_a_q > pk_r_val_q)) begin
                            pk_r_val_d = grad_a_q;
                            pk_r_pos_d = grad_k_q;
                        end
                    end
                end
                if (issue_done_q) begin
                    grad_v_d = 1'b0;
                    state_d  = S_CALC;
                end else begin
                    grad_v_d = 1'b1;
                    grad_a_d = grad_abs;
                    grad_k_d = k_q;
                    if (k_q == IDX_W'(LAST_K)) begin
                        issue_done_d = 1'b1;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
            end

            S_CALC: begin
                if (pk_found) begin
                    tx_center_d   = centre;
                    tx_conf_d     = conf_sat;
                    tx_lost_d     = 1'b0;
                    last_center_d = centre;
                    miss_cnt_d    = '0;
                end else if (miss_cnt_q < MISS_W'(HOLD_ROWS)) begin
                    tx_center_d = last_center_q;
                    tx_conf_d   = 8'd0;
                    tx_lost_d   = 1'b0;
                    miss_cnt_d  = miss_cnt_q + MISS_W'(1);
                end else begin
                    tx_center_d = last_center_q;
                    tx_conf_d   = 8'd0;
                    tx_lost_d   = 1'b1;
                end
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end

            S_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (AUTO_RESTART) begin
                        state_d = S_RECEIVE;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset makes every row report lost until a lane is found.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < ROW_W; i++) begin
                pix_q[i] <= '0;
            end
            idx_q         <= '0;
            k_q           <= '0;
            issue_done_q  <= 1'b0;
            grad_v_q      <= 1'b0;
            grad_a_q      <= '0;
            grad_k_q      <= '0;
            pk_l_val_q    <= '0;
            pk_r_val_q    <= '0;
            pk_l_pos_q    <= '0;
            pk_r_pos_q    <= '0;
            last_center_q <= '0;
            miss_cnt_q    <= MISS_W'(HOLD_ROWS);
            tx_center_q   <= '0;
            tx_conf_q     <= 8'd0;
            tx_lost_q     <= 1'b1;
            tx_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_q         <= pix_d;
            idx_q         <= idx_d;
            k_q           <= k_d;
            issue_done_q  <= issue_done_d;
            grad_v_q      <= grad_v_d;
            grad_a_q      <= grad_a_d;
            grad_k_q      <= grad_k_d;
            pk_l_val_q    <= pk_l_val_d;
            pk_r_val_q    <= pk_r_val_d;
            pk_l_pos_q    <= pk_l_pos_d;
            pk_r_pos_q    <= pk_r_pos_d;
            last_center_q <= last_center_d;
            miss_cnt_q    <= miss_cnt_d;
            tx_center_q   <= tx_center_d;
            tx_conf_q     <= tx_conf_d;
            tx_lost_q     <= tx_lost_d;
            tx_valid_q    <= tx_valid_d;
        end
    end

endmodule

// File: tb/tb_lane_tracker_stream.sv
// tb/tb_lane_tracker_stream.sv - Directed bench with behavioural lane model for lane_tracker_stream
module tb_lane_tracker_stream;

    localparam int ROW_W     = 32;
    localparam int PIX_W     = 8;
    localparam int THRESH    = 20;
    localparam int HOLD_ROWS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [4:0] tx_center;
    logic [7:0] tx_confidence;
    logic       tx_lost;
    logic       tx_valid;
    logic       tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e_cyc = 0;
    int lat = 0;

    logic [7:0] cur_row [ROW_W];
    int q_c[$];
    int q_f[$];
    int q_l[$];
    int m_last = 0;
    int m_miss = HOLD_ROWS;

    logic [4:0] hold_c;
    logic [7:0] hold_f;
    logic       hold_l;

    lane_tracker_stream #(
        .ROW_W(ROW_W),
        .PIX_W(PIX_W),
        .THRESH(THRESH),
        .HOLD_ROWS(HOLD_ROWS),
        .AUTO_RESTART(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_center(tx_center),
        .tx_confidence(tx_confidence),
        .tx_lost(tx_lost),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Behavioural reference: scan the stored row with plain integer arithmetic.
    task automatic model_row();
        int lv, rv, lp, rp, a, c, f, l;
        lv = 0; rv = 0; lp = 0; rp = 0;
        for (int k = 0; k <= ROW_W - 3; k++) begin
            a = int'(cur_row[k + 2]) - int'(cur_row[k]);
            if (a < 0) a = -a;
            if (k < (ROW_W - 2) / 2) begin
                if (a > THRESH && a > lv) begin lv = a; lp = k; end
            end else begin
                if (a > THRESH && a > rv) begin rv = a; rp = k; end
            end
        end
        if (lv > 0 && rv > 0) begin
            c = (lp + rp) / 2;
            f = (lv + rv) / 2;
            if (f > 255) f = 255;
            l = 0;
            m_last = c;
            m_miss = 0;
        end else begin
            c = m_last;
            f = 0;
            if (m_miss < HOLD_ROWS) begin
                l = 0;
                m_miss++;
            end else begin
                l = 1;
            end
        end
        q_c.push_back(c);
        q_f.push_back(f);
        q_l.push_back(l);
    endtask

    task automatic set_flat(input int v);
        for (int i = 0; i < ROW_W; i++) cur_row[i] = 8'(v);
    endtask

    task automatic set_step(input int amp);
        for (int i = 0; i < ROW_W; i++) cur_row[i] = (i >= 6 && i <= 25) ? 8'(amp) : 8'd0;
    endtask

    task automatic set_two_step();
        for (int i = 0; i < ROW_W; i++) cur_row[i] = (i < 3) ? 8'd0 : ((i < 20) ? 8'd50 : 8'd120);
    endtask

    task automatic send_row(input bit gaps, input int npix);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (i < npix && guard < 500) begin
            rx_valid = gaps ? (guard % 2 == 0) : 1'b1;
            rx_data  = cur_row[i];
            acc = rx_valid && rx_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        rx_valid = 1'b0;
        if (i < npix) begin
            checks++;
            errors++;
            $display("FAIL send_row_timeout: got %0d pixels, expected %0d", i, npix);
        end
        e_cyc = cyc;
        if (npix == ROW_W) model_row();
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!tx_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tx_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_tx_valid_timeout: got tx_valid=0 after %0d cycles, expected 1", n);
        end
        lat = cyc - e_cyc;
    endtask

    task automatic run_row(input string name, input bit gaps, input int ec, input int ef, input int el);
        send_row(gaps, ROW_W);
        wait_result();
        check({name, "_latency"}, lat, 32);
        check({name, "_center"}, tx_center, ec);
        check({name, "_conf"}, tx_confidence, ef);
        check({name, "_lost"}, tx_lost, el);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_valid_drop"}, tx_valid, 0);
    endtask

    // Every cycle a result is presented it must match the oldest model prediction.
    always @(negedge clk) begin
        if (!rst && tx_valid) begin
            if (q_c.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmp_unexpected_valid: got tx_valid=1, expected 0");
            end else begin
                check("cmp_center", tx_center, q_c[0]);
                check("cmp_conf", tx_confidence, q_f[0]);
                check("cmp_lost", tx_lost, q_l[0]);
                if (tx_ready) begin
                    void'(q_c.pop_front());
                    void'(q_f.pop_front());
                    void'(q_l.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rx_ready", rx_ready, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_center", tx_center, 0);
        check("reset_tx_conf", tx_confidence, 0);
        check("reset_tx_lost", tx_lost, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_rx_ready", rx_ready, 0);

        tx_ready = 1'b1;
        set_flat(100);
        run_row("flat_after_reset", 0, 0, 0, 1);

        set_step(200);
        run_row("good", 0, 14, 200, 0);

        set_flat(100);
        run_row("hold1", 0, 14, 0, 0);
        run_row("hold2", 0, 14, 0, 0);
        run_row("hold3", 0, 14, 0, 1);

        set_step(200);
        run_row("recover", 0, 14, 200, 0);

        set_step(20);
        run_row("amp20", 0, 14, 0, 0);
        set_step(21);
        run_row("amp21", 0, 14, 21, 0);

        set_two_step();
        run_row("two_step", 0, 9, 60, 0);

        tx_ready = 1'b0;
        set_step(90);
        send_row(0, ROW_W);
        wait_result();
        check("bp_latency", lat, 32);
        check("bp_center", tx_center, 14);
        check("bp_conf", tx_confidence, 90);
        hold_c = tx_center;
        hold_f = tx_confidence;
        hold_l = tx_lost;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", tx_valid, 1);
            check("bp_hold_center", tx_center, hold_c);
            check("bp_hold_conf", tx_confidence, hold_f);
            check("bp_hold_lost", tx_lost, hold_l);
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", tx_valid, 0);

        set_step(200);
        run_row("gaps", 1, 14, 200, 0);

        set_step(200);
        send_row(0, 10);
        rst = 1'b1;
        #1;
        check("midrst_rx_ready", rx_ready, 0);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_tx_lost", tx_lost, 1);
        check("midrst_tx_center", tx_center, 0);
        m_last = 0;
        m_miss = HOLD_ROWS;
        q_c.delete();
        q_f.delete();
        q_l.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_row("after_rst", 0, 14, 200, 0);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", q_c.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
